// File: rtl/arb_stream_pkg.sv
// arb_stream_pkg
// Shared definitions for the arbiter-to-SRAM stream buffer:
//   DATA_W     - width of one stream word (32 bits)
//   ptr_width  - pointer width for a given storage depth (log2 of depth)
package arb_stream_pkg;

    localparam int DATA_W = 32;

    // Depth is a power of two, so log2 gives a pointer that wraps
    // naturally modulo DEPTH. The floor of 1 keeps degenerate depths legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_stream_ram.sv
// arb_stream_ram
// Simple dual-port storage for the stream buffer: synchronous write,
// asynchronous read, DEPTH words of DATA_W bits. Contents are not reset;
// the top level masks the read data whenever the buffer is empty.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module arb_stream_ram
    import arb_stream_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arb_stream_buffer.sv
// arb_stream_buffer
// First-word-fall-through buffer between an upstream arbiter and a
// downstream SRAM FIFO. Holds the pointers, fill counter, sticky error
// flags and (optionally) statistics; storage lives in arb_stream_ram.
//
// Optional feature: define ARB_STREAM_STATS_EN to add WORD_COUNT and
// MAX_FILL outputs. Without it those ports and registers do not exist.
//
// Ports:
//   BUS_CLK        - clock, rising edge
//   BUS_RST_N      - synchronous active-low reset
//   IN_WRITE       - upstream presents a word
//   IN_DATA        - upstream word
//   IN_READY       - buffer accepts a word this cycle
//   OUT_READ_NEXT  - downstream pops the current output word
//   OUT_EMPTY      - no valid output word
//   OUT_DATA       - current output word (fall-through, 0 when empty)
//   FILL_LEVEL     - words stored
//   NEAR_FULL      - FILL_LEVEL >= NEAR_FULL_LEVEL
//   OVERFLOW_ERR   - sticky: write attempted while not ready
//   READ_ERR       - sticky: pop attempted while empty
//   ERR_CLEAR      - pulse clearing sticky flags (and statistics)
//   WORD_COUNT     - (stats) accepted writes, wraps at 2^32
//   MAX_FILL       - (stats) peak FILL_LEVEL
//
// Handshake: a write transfers only when IN_WRITE and IN_READY are both
// high in the same cycle; a pop transfers only when OUT_READ_NEXT is high
// and OUT_EMPTY is low. Any other request is ignored by the data path and
// only raises the matching sticky error flag.
module arb_stream_buffer
    import arb_stream_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int NEAR_FULL_LEVEL = 12
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST_N,
    input  logic                   IN_WRITE,
    input  logic [DATA_W-1:0]      IN_DATA,
    output logic                   IN_READY,
    input  logic                   OUT_READ_NEXT,
    output logic                   OUT_EMPTY,
    output logic [DATA_W-1:0]      OUT_DATA,
    output logic [$clog2(DEPTH):0] FILL_LEVEL,
    output logic                   NEAR_FULL,
    output logic                   OVERFLOW_ERR,
    output logic                   READ_ERR,
    input  logic                   ERR_CLEAR
`ifdef ARB_STREAM_STATS_EN
    ,
    output logic [31:0]            WORD_COUNT,
    output logic [$clog2(DEPTH):0] MAX_FILL
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] NEAR_LVL  = LVL_W'(NEAR_FULL_LEVEL);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  fill_q;
    logic [LVL_W-1:0]  fill_next;
    logic              ready_en;
    logic              overflow_q;
    logic              read_err_q;
    logic [DATA_W-1:0] ram_rdata;

    logic do_write;
    logic do_pop;
    logic overflow_evt;
    logic read_err_evt;

    // ready_en is cleared by reset and set on the first edge after release,
    // so IN_READY is low throughout reset and rises one cycle later.
    // Readiness looks only at the stored level, never at a same-cycle pop.
    assign IN_READY  = ready_en & (fill_q < DEPTH_LVL);
    assign OUT_EMPTY = (fill_q == '0);
    assign NEAR_FULL = (fill_q >= NEAR_LVL);

    assign do_write     = IN_WRITE & IN_READY;
    assign do_pop       = OUT_READ_NEXT & ~OUT_EMPTY;
    assign overflow_evt = IN_WRITE & ~IN_READY;
    assign read_err_evt = OUT_READ_NEXT & OUT_EMPTY;

    always_comb begin
        fill_next = fill_q;
        if (do_write && !do_pop) begin
            fill_next = fill_q + LVL_ONE;
        end else if (do_pop && !do_write) begin
            fill_next = fill_q - LVL_ONE;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            ready_en   <= 1'b0;
            overflow_q <= 1'b0;
            read_err_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            fill_q   <= fill_next;
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A new error event in the clearing cycle keeps the flag set.
            overflow_q <= (overflow_q & ~ERR_CLEAR) | overflow_evt;
            read_err_q <= (read_err_q & ~ERR_CLEAR) | read_err_evt;
        end
    end

    arb_stream_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (BUS_CLK),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (IN_DATA),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Masking with OUT_EMPTY keeps stale RAM contents invisible after reset.
    assign OUT_DATA     = OUT_EMPTY ? '0 : ram_rdata;
    assign FILL_LEVEL   = fill_q;
    assign OVERFLOW_ERR = overflow_q;
    assign READ_ERR     = read_err_q;

`ifdef ARB_STREAM_STATS_EN
    logic [31:0]      word_count_q;
    logic [LVL_W-1:0] max_fill_q;

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N || ERR_CLEAR) begin
            word_count_q <= '0;
            max_fill_q   <= '0;
        end else begin
            if (do_write) begin
                word_count_q <= word_count_q + 32'd1;
            end
            // Track the level the buffer is about to hold.
            if (fill_next > max_fill_q) begin
                max_fill_q <= fill_next;
            end
        end
    end

    assign WORD_COUNT = word_count_q;
    assign MAX_FILL   = max_fill_q;
`endif

endmodule

// File: tb/tb_arb_stream_buffer.sv
// tb_arb_stream_buffer
// Directed self-checking bench for arb_stream_buffer (DEPTH=16,
// NEAR_FULL_LEVEL=12). Inputs change 1 time unit after each rising edge,
// outputs are sampled at that same point, before the inputs change.
// The statistics scenario is compiled in only with ARB_STREAM_STATS_EN.
module tb_arb_stream_buffer;

    logic        BUS_CLK;
    logic        BUS_RST_N;
    logic        IN_WRITE;
    logic [31:0] IN_DATA;
    logic        IN_READY;
    logic        OUT_READ_NEXT;
    logic        OUT_EMPTY;
    logic [31:0] OUT_DATA;
    logic [4:0]  FILL_LEVEL;
    logic        NEAR_FULL;
    logic        OVERFLOW_ERR;
    logic        READ_ERR;
    logic        ERR_CLEAR;
`ifdef ARB_STREAM_STATS_EN
    logic [31:0] WORD_COUNT;
    logic [4:0]  MAX_FILL;
`endif

    int n_cmp;
    int n_err;

    arb_stream_buffer #(
        .DEPTH           (16),
        .NEAR_FULL_LEVEL (12)
    ) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST_N     (BUS_RST_N),
        .IN_WRITE      (IN_WRITE),
        .IN_DATA       (IN_DATA),
        .IN_READY      (IN_READY),
        .OUT_READ_NEXT (OUT_READ_NEXT),
        .OUT_EMPTY     (OUT_EMPTY),
        .OUT_DATA      (OUT_DATA),
        .FILL_LEVEL    (FILL_LEVEL),
        .NEAR_FULL     (NEAR_FULL),
        .OVERFLOW_ERR  (OVERFLOW_ERR),
        .READ_ERR      (READ_ERR),
        .ERR_CLEAR     (ERR_CLEAR)
`ifdef ARB_STREAM_STATS_EN
        ,
        .WORD_COUNT    (WORD_COUNT),
        .MAX_FILL      (MAX_FILL)
`endif
    );

    // ---------------- clock ----------------
    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IN_WRITE      = 1'b0;
        IN_DATA       = '0;
        OUT_READ_NEXT = 1'b0;
        ERR_CLEAR     = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        BUS_RST_N = 1'b0;
        idle_inputs();
        step();
        step();
        n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b exp 0", IN_READY); end
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_out_empty: got %b exp 1", OUT_EMPTY); end
        n_cmp++; if (FILL_LEVEL !== 5'd0) begin n_err++; $display("FAIL reset_fill: got %0d exp 0", FILL_LEVEL); end
        n_cmp++; if (NEAR_FULL !== 1'b0) begin n_err++; $display("FAIL reset_near_full: got %b exp 0", NEAR_FULL); end
        n_cmp++; if (OVERFLOW_ERR !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b exp 0", OVERFLOW_ERR); end
        n_cmp++; if (READ_ERR !== 1'b0) begin n_err++; $display("FAIL reset_read_err: got %b exp 0", READ_ERR); end
        n_cmp++; if (OUT_DATA !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h exp 0", OUT_DATA); end
        BUS_RST_N = 1'b1;
        step();
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready_rise: got %b exp 1", IN_READY); end
    endtask

    task automatic test_single_word();
        IN_WRITE = 1'b1;
        IN_DATA  = 32'hDEADBEEF;
        step();
        idle_inputs();
        n_cmp++; if (OUT_EMPTY !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b exp 0", OUT_EMPTY); end
        n_cmp++; if (OUT_DATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h exp deadbeef", OUT_DATA); end
        n_cmp++; if (FILL_LEVEL !== 5'd1) begin n_err++; $display("FAIL single_fill: got %0d exp 1", FILL_LEVEL); end
        step();
        n_cmp++; if (OUT_DATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold: got %h exp deadbeef", OUT_DATA); end
        OUT_READ_NEXT = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b exp 1", OUT_EMPTY); end
        n_cmp++; if (READ_ERR !== 1'b0) begin n_err++; $display("FAIL single_no_read_err: got %b exp 0", READ_ERR); end
    endtask

    // 40 incrementing words, pops on a random schedule; each popped word is
    // checked against the scoreboard queue.
    task automatic test_fill_wrap();
        logic [31:0] exp_q[$];
        int          wr_idx;
        int          popped;
        int          cycles;
        logic        pop;
        wr_idx = 0;
        popped = 0;
        cycles = 0;
        while (popped < 40 && cycles < 600) begin
            IN_WRITE = 1'b0;
            if (wr_idx < 40 && IN_READY) begin
                IN_WRITE = 1'b1;
                IN_DATA  = 32'(wr_idx);
                exp_q.push_back(32'(wr_idx));
                wr_idx++;
            end
            pop = (($urandom_range(0, 2) != 0) || wr_idx >= 40) && !OUT_EMPTY;
            OUT_READ_NEXT = pop;
            if (pop) begin
                n_cmp++;
                if (OUT_DATA !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL wrap_order: got %0d exp %0d", OUT_DATA, exp_q[0]);
                end
                void'(exp_q.pop_front());
                popped++;
            end
            step();
            cycles++;
        end
        idle_inputs();
        n_cmp++; if (popped !== 40) begin n_err++; $display("FAIL wrap_timeout: got %0d popped exp 40", popped); end
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL wrap_drained: got %b exp 1", OUT_EMPTY); end
        n_cmp++; if (OVERFLOW_ERR !== 1'b0 || READ_ERR !== 1'b0) begin n_err++; $display("FAIL wrap_no_errors: got %b%b exp 00", OVERFLOW_ERR, READ_ERR); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            IN_WRITE = 1'b1;
            IN_DATA  = 32'h100 + 32'(i);
            step();
            if (i == 10) begin
                n_cmp++; if (NEAR_FULL !== 1'b0) begin n_err++; $display("FAIL full_near_at_11: got %b exp 0", NEAR_FULL); end
            end
            if (i == 11) begin
                n_cmp++; if (NEAR_FULL !== 1'b1) begin n_err++; $display("FAIL full_near_at_12: got %b exp 1", NEAR_FULL); end
            end
        end
        idle_inputs();
        n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b exp 0", IN_READY); end
        n_cmp++; if (NEAR_FULL !== 1'b1) begin n_err++; $display("FAIL full_near: got %b exp 1", NEAR_FULL); end
        n_cmp++; if (FILL_LEVEL !== 5'd16) begin n_err++; $display("FAIL full_level: got %0d exp 16", FILL_LEVEL); end
        n_cmp++; if (OVERFLOW_ERR !== 1'b0) begin n_err++; $display("FAIL full_no_overflow_yet: got %b exp 0", OVERFLOW_ERR); end
        // 17th word must be dropped.
        IN_WRITE = 1'b1;
        IN_DATA  = 32'hBAD0BAD0;
        step();
        idle_inputs();
        n_cmp++; if (OVERFLOW_ERR !== 1'b1) begin n_err++; $display("FAIL full_overflow: got %b exp 1", OVERFLOW_ERR); end
        n_cmp++; if (FILL_LEVEL !== 5'd16) begin n_err++; $display("FAIL full_drop_level: got %0d exp 16", FILL_LEVEL); end
        n_cmp++; if (OUT_DATA !== 32'h100) begin n_err++; $display("FAIL full_head: got %h exp 100", OUT_DATA); end
        // Pop and write together while full: ready stays low, write dropped.
        IN_WRITE      = 1'b1;
        IN_DATA       = 32'hBAD1BAD1;
        OUT_READ_NEXT = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (FILL_LEVEL !== 5'd15) begin n_err++; $display("FAIL full_pop_write_level: got %0d exp 15", FILL_LEVEL); end
        n_cmp++; if (OUT_DATA !== 32'h101) begin n_err++; $display("FAIL full_pop_write_head: got %h exp 101", OUT_DATA); end
        ERR_CLEAR = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (OVERFLOW_ERR !== 1'b0) begin n_err++; $display("FAIL full_clear: got %b exp 0", OVERFLOW_ERR); end
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (OUT_DATA !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL full_drain: got %h exp %h", OUT_DATA, 32'h100 + 32'(i)); end
            OUT_READ_NEXT = 1'b1;
            step();
        end
        idle_inputs();
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL full_drain_empty: got %b exp 1", OUT_EMPTY); end
    endtask

    task automatic test_empty_pop();
        OUT_READ_NEXT = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (READ_ERR !== 1'b1) begin n_err++; $display("FAIL empty_read_err: got %b exp 1", READ_ERR); end
        n_cmp++; if (FILL_LEVEL !== 5'd0) begin n_err++; $display("FAIL empty_level: got %0d exp 0", FILL_LEVEL); end
        // Clear and new error together: set wins.
        OUT_READ_NEXT = 1'b1;
        ERR_CLEAR     = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (READ_ERR !== 1'b1) begin n_err++; $display("FAIL empty_set_wins: got %b exp 1", READ_ERR); end
        ERR_CLEAR = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (READ_ERR !== 1'b0) begin n_err++; $display("FAIL empty_clear: got %b exp 0", READ_ERR); end
        // Write and pop on an empty buffer: write taken, pop ignored.
        IN_WRITE      = 1'b1;
        IN_DATA       = 32'h55;
        OUT_READ_NEXT = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (FILL_LEVEL !== 5'd1) begin n_err++; $display("FAIL empty_wp_level: got %0d exp 1", FILL_LEVEL); end
        n_cmp++; if (OUT_DATA !== 32'h55) begin n_err++; $display("FAIL empty_wp_data: got %h exp 55", OUT_DATA); end
        n_cmp++; if (READ_ERR !== 1'b1) begin n_err++; $display("FAIL empty_wp_read_err: got %b exp 1", READ_ERR); end
        OUT_READ_NEXT = 1'b1;
        ERR_CLEAR     = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (OUT_EMPTY !== 1'b1 || READ_ERR !== 1'b0) begin n_err++; $display("FAIL empty_wp_drain: got %b%b exp 10", OUT_EMPTY, READ_ERR); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 7; i++) begin
            IN_WRITE = 1'b1;
            IN_DATA  = 32'h200 + 32'(i);
            step();
        end
        idle_inputs();
        n_cmp++; if (FILL_LEVEL !== 5'd7) begin n_err++; $display("FAIL mid_level_before: got %0d exp 7", FILL_LEVEL); end
        BUS_RST_N = 1'b0;
        step();
        BUS_RST_N = 1'b1;
        n_cmp++; if (FILL_LEVEL !== 5'd0) begin n_err++; $display("FAIL mid_level_after: got %0d exp 0", FILL_LEVEL); end
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b exp 1", OUT_EMPTY); end
        n_cmp++; if (OUT_DATA !== 32'h0) begin n_err++; $display("FAIL mid_data_zero: got %h exp 0", OUT_DATA); end
        step();
        IN_WRITE = 1'b1;
        IN_DATA  = 32'h1;
        step();
        idle_inputs();
        n_cmp++; if (OUT_DATA !== 32'h1) begin n_err++; $display("FAIL mid_first_word: got %h exp 1", OUT_DATA); end
        n_cmp++; if (FILL_LEVEL !== 5'd1) begin n_err++; $display("FAIL mid_first_level: got %0d exp 1", FILL_LEVEL); end
        OUT_READ_NEXT = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (OUT_EMPTY !== 1'b1) begin n_err++; $display("FAIL mid_no_stale: got %b exp 1", OUT_EMPTY); end
    endtask

`ifdef ARB_STREAM_STATS_EN
    task automatic test_stats();
        ERR_CLEAR = 1'b1;
        step();
        idle_inputs();
        // 9 writes build occupancy 9, then 91 write+pop cycles hold it.
        for (int i = 0; i < 100; i++) begin
            IN_WRITE      = 1'b1;
            IN_DATA       = 32'(i);
            OUT_READ_NEXT = (i >= 9);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 9; i++) begin
            OUT_READ_NEXT = 1'b1;
            step();
        end
        idle_inputs();
        n_cmp++; if (WORD_COUNT !== 32'd100) begin n_err++; $display("FAIL stats_count: got %0d exp 100", WORD_COUNT); end
        n_cmp++; if (MAX_FILL !== 5'd9) begin n_err++; $display("FAIL stats_max: got %0d exp 9", MAX_FILL); end
        ERR_CLEAR = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (WORD_COUNT !== 32'd0 || MAX_FILL !== 5'd0) begin n_err++; $display("FAIL stats_clear: got %0d/%0d exp 0/0", WORD_COUNT, MAX_FILL); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_word();
        test_fill_wrap();
        test_full();
        test_empty_pop();
        test_reset_midstream();
`ifdef ARB_STREAM_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
